// File: rtl/freelist_alloc_ctrl.sv
// Rename/commit front-end for the physical-register freelist: gates and compacts 2-wide
// allocation, forwards registered frees, mirrors the free count. Optional: FREELIST_ALLOC_CTRL_CHK_EN.
module freelist_alloc_ctrl #(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned LOG_NUM_REGS   = 5,
  parameter int unsigned PREG_IDX_WIDTH = 6,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [1:0]                rn_valid,
  output logic                      rn_ready,
  output logic [PREG_IDX_WIDTH-1:0] rn0_preg,
  output logic [PREG_IDX_WIDTH-1:0] rn1_preg,
  output logic                      fl_req0_valid,
  output logic                      fl_req1_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req0_data,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req1_data,
  input  logic [1:0]                cm_valid,
  input  logic [PREG_IDX_WIDTH-1:0] cm0_preg,
  input  logic [PREG_IDX_WIDTH-1:0] cm1_preg,
  output logic                      fl_wr0_valid,
  output logic                      fl_wr1_valid,
  output logic [PREG_IDX_WIDTH-1:0] fl_wr0_data,
  output logic [PREG_IDX_WIDTH-1:0] fl_wr1_data,
  output logic [LOG_NUM_REGS:0]     avail_count,
  output logic                      err
);

  localparam int unsigned CNT_W   = LOG_NUM_REGS + 1;
  localparam int unsigned SUM_W   = LOG_NUM_REGS + 3;
  localparam int unsigned DRAIN_W = 4;
  localparam logic signed [SUM_W-1:0] NUM_REGS_S = SUM_W'(NUM_REGS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [1:0]           need;
  logic                 alloc_go;
  logic [1:0]           req_cnt;
  logic [1:0]           wr_cnt;
  logic signed [SUM_W-1:0] sum_next;
  logic                 cnt_over;
  logic                 cnt_under;
  logic [CNT_W-1:0]     avail_next;

  // Flush/drain sequencing; flush wins from any state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else if (flush) begin
      state     <= FLUSH;
      drain_cnt <= '0;
    end else begin
      case (state)
        FLUSH: begin
          state     <= DRAIN;
          drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= RUN;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  assign need     = 2'({1'b0, rn_valid[0]} + {1'b0, rn_valid[1]});
  assign rn_ready = (state == RUN) && !flush && (CNT_W'(need) <= avail_count);
  assign alloc_go = rn_ready && (need != 2'd0);

  // The first requesting lane always takes the freelist head port
  assign fl_req0_valid = alloc_go;
  assign fl_req1_valid = alloc_go && (need == 2'd2);
  assign rn0_preg      = (alloc_go && rn_valid[0]) ? fl_req0_data : '0;
  assign rn1_preg      = (alloc_go && rn_valid[1])
                         ? (rn_valid[0] ? fl_req1_data : fl_req0_data) : '0;

  // Frees are compacted on the way into the register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fl_wr0_valid <= 1'b0;
      fl_wr1_valid <= 1'b0;
      fl_wr0_data  <= '0;
      fl_wr1_data  <= '0;
    end else begin
      fl_wr0_valid <= |cm_valid;
      fl_wr1_valid <= &cm_valid;
      fl_wr0_data  <= cm_valid[0] ? cm0_preg : (cm_valid[1] ? cm1_preg : '0);
      fl_wr1_data  <= (&cm_valid) ? cm1_preg : '0;
    end
  end

  assign req_cnt = 2'({1'b0, fl_req0_valid} + {1'b0, fl_req1_valid});
  assign wr_cnt  = 2'({1'b0, fl_wr0_valid} + {1'b0, fl_wr1_valid});

  // Signed headroom so both overflow and underflow are visible before clamping
  assign sum_next  = $signed(SUM_W'(avail_count)) + $signed(SUM_W'(wr_cnt))
                   - $signed(SUM_W'(req_cnt));
  assign cnt_under = sum_next[SUM_W-1];
  assign cnt_over  = !cnt_under && (sum_next > NUM_REGS_S);

  always_comb begin
    avail_next = sum_next[CNT_W-1:0];
    if (cnt_under) begin
      avail_next = '0;
    end else if (cnt_over) begin
      avail_next = CNT_W'(NUM_REGS);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avail_count <= CNT_W'(NUM_REGS);
    end else begin
      avail_count <= avail_next;
    end
  end

`ifdef FREELIST_ALLOC_CTRL_CHK_EN
  logic err_q;

  // Sticky until reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (cnt_over || cnt_under) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_alloc_ctrl.sv
// Scoreboard bench for freelist_alloc_ctrl: directed stimulus pushes expected grants/frees,
// a negedge monitor pops and compares whenever the DUT strobes the freelist ports.
module tb_freelist_alloc_ctrl;

  localparam int unsigned PW = 6;

`ifdef FREELIST_ALLOC_CTRL_CHK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [1:0]    rn_valid;
  logic          rn_ready;
  logic [PW-1:0] rn0_preg, rn1_preg;
  logic          fl_req0_valid, fl_req1_valid;
  logic [PW-1:0] fl_req0_data, fl_req1_data;
  logic [1:0]    cm_valid;
  logic [PW-1:0] cm0_preg, cm1_preg;
  logic          fl_wr0_valid, fl_wr1_valid;
  logic [PW-1:0] fl_wr0_data, fl_wr1_data;
  logic [5:0]    avail_count;
  logic          err;

  freelist_alloc_ctrl dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .rn_valid(rn_valid), .rn_ready(rn_ready), .rn0_preg(rn0_preg), .rn1_preg(rn1_preg),
    .fl_req0_valid(fl_req0_valid), .fl_req1_valid(fl_req1_valid),
    .fl_req0_data(fl_req0_data), .fl_req1_data(fl_req1_data),
    .cm_valid(cm_valid), .cm0_preg(cm0_preg), .cm1_preg(cm1_preg),
    .fl_wr0_valid(fl_wr0_valid), .fl_wr1_valid(fl_wr1_valid),
    .fl_wr0_data(fl_wr0_data), .fl_wr1_data(fl_wr1_data),
    .avail_count(avail_count), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          v0;
    logic          v1;
    logic [PW-1:0] d0;
    logic [PW-1:0] d1;
  } rec_t;

  rec_t q_alloc[$];
  rec_t q_free[$];
  rec_t ea, ef;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_alloc(input logic v0, input logic v1, input int d0, input int d1);
    rec_t r;
    r.v0 = v0; r.v1 = v1; r.d0 = PW'(d0); r.d1 = PW'(d1);
    q_alloc.push_back(r);
  endtask

  task automatic push_free(input logic v0, input logic v1, input int d0, input int d1);
    rec_t r;
    r.v0 = v0; r.v1 = v1; r.d0 = PW'(d0); r.d1 = PW'(d1);
    q_free.push_back(r);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare each freelist-port strobe against the head of its queue
  always @(negedge clock) begin
    if (reset_n) begin
      if (fl_req0_valid || fl_req1_valid) begin
        if (q_alloc.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL alloc_unexpected: got req %0b%0b expected none (t=%0t)",
                   fl_req0_valid, fl_req1_valid, $time);
        end else begin
          ea = q_alloc.pop_front();
          chk("alloc_req0_valid", int'(fl_req0_valid), int'(ea.v0));
          chk("alloc_req1_valid", int'(fl_req1_valid), int'(ea.v1));
          chk("alloc_rn0_preg", int'(rn0_preg), int'(ea.d0));
          chk("alloc_rn1_preg", int'(rn1_preg), int'(ea.d1));
        end
      end else begin
        chk("idle_rn_pregs", int'({rn0_preg, rn1_preg}), 0);
      end
      if (fl_wr0_valid || fl_wr1_valid) begin
        if (q_free.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL free_unexpected: got wr %0b%0b expected none (t=%0t)",
                   fl_wr0_valid, fl_wr1_valid, $time);
        end else begin
          ef = q_free.pop_front();
          chk("free_wr0_valid", int'(fl_wr0_valid), int'(ef.v0));
          chk("free_wr1_valid", int'(fl_wr1_valid), int'(ef.v1));
          chk("free_wr0_data", int'(fl_wr0_data), int'(ef.d0));
          if (ef.v1) chk("free_wr1_data", int'(fl_wr1_data), int'(ef.d1));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; rn_valid = 2'b00; cm_valid = 2'b00;
    cm0_preg = '0; cm1_preg = '0; fl_req0_data = '0; fl_req1_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_avail", int'(avail_count), 32);
    chk("rst_ready", int'(rn_ready), 1);
    chk("rst_req", int'({fl_req0_valid, fl_req1_valid}), 0);
    chk("rst_wr", int'({fl_wr0_valid, fl_wr1_valid}), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pregs", int'({rn0_preg, rn1_preg}), 0);
    reset_n = 1'b1;

    // Dual grant from full
    cyc();
    rn_valid = 2'b11; fl_req0_data = 6'd10; fl_req1_data = 6'd11;
    push_alloc(1, 1, 10, 11);
    #1 chk("dual_ready", int'(rn_ready), 1);
    cyc();
    rn_valid = 2'b00;
    #1 chk("avail_after_dual", int'(avail_count), 30);

    // Consume down to one free entry
    for (int i = 0; i < 14; i++) begin
      cyc();
      rn_valid = 2'b11; fl_req0_data = PW'(i); fl_req1_data = PW'(i + 32);
      push_alloc(1, 1, i, i + 32);
    end
    cyc();
    rn_valid = 2'b01; fl_req0_data = 6'd50; fl_req1_data = 6'd51;
    push_alloc(1, 0, 50, 0);
    cyc();
    rn_valid = 2'b00;
    #1 chk("avail_one", int'(avail_count), 1);

    // Insufficient for two, then single lane 1 compacts onto port 0
    cyc();
    rn_valid = 2'b11; fl_req0_data = 6'd20; fl_req1_data = 6'd21;
    #1 chk("short_ready", int'(rn_ready), 0);
    cyc();
    rn_valid = 2'b10; fl_req0_data = 6'd22; fl_req1_data = 6'd23;
    push_alloc(1, 0, 0, 22);
    #1 chk("lane1_ready", int'(rn_ready), 1);
    cyc();
    rn_valid = 2'b01;
    #1 chk("empty_ready", int'(rn_ready), 0);
    chk("avail_zero", int'(avail_count), 0);

    // Single free on lane 1
    cyc();
    rn_valid = 2'b00; cm_valid = 2'b10; cm0_preg = 6'd7; cm1_preg = 6'd40;
    push_free(1, 0, 40, 0);
    cyc();
    cm_valid = 2'b00;
    #1 chk("free_latency_avail", int'(avail_count), 0);
    cyc();
    #1 chk("avail_after_free1", int'(avail_count), 1);

    // Double free
    cm_valid = 2'b11; cm0_preg = 6'd3; cm1_preg = 6'd4;
    push_free(1, 1, 3, 4);
    cyc();
    cm_valid = 2'b00;
    #1 chk("avail_before_free2", int'(avail_count), 1);
    cyc();
    #1 chk("avail_after_free2", int'(avail_count), 3);

    // Grant of two and free of two in the same cycle
    cm_valid = 2'b11; cm0_preg = 6'd5; cm1_preg = 6'd6;
    push_free(1, 1, 5, 6);
    cyc();
    cm_valid = 2'b00; rn_valid = 2'b11; fl_req0_data = 6'd12; fl_req1_data = 6'd13;
    push_alloc(1, 1, 12, 13);
    #1 chk("net_ready", int'(rn_ready), 1);
    cyc();
    rn_valid = 2'b00;
    #1 chk("avail_net_zero", int'(avail_count), 3);

    // Flush for three cycles with a free in flight
    flush = 1'b1; rn_valid = 2'b11; fl_req0_data = 6'd30; fl_req1_data = 6'd31;
    #1 chk("flush_ready_c0", int'(rn_ready), 0);
    cyc();
    cm_valid = 2'b01; cm0_preg = 6'd9;
    push_free(1, 0, 9, 0);
    #1 chk("flush_ready_c1", int'(rn_ready), 0);
    cyc();
    cm_valid = 2'b00;
    #1 chk("flush_ready_c2", int'(rn_ready), 0);
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("drain_ready", int'(rn_ready), 0);
      cyc();
    end
    push_alloc(1, 1, 30, 31);
    #1 chk("post_drain_ready", int'(rn_ready), 1);
    chk("avail_post_flush", int'(avail_count), 4);
    cyc();
    rn_valid = 2'b00;
    #1 chk("avail_after_drain_grant", int'(avail_count), 2);

    // Reset during drain discards the registered free
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    cm_valid = 2'b11; cm0_preg = 6'd1; cm1_preg = 6'd2;
    cyc();
    cm_valid = 2'b00; reset_n = 1'b0;
    #1 chk("midrst_wr", int'({fl_wr0_valid, fl_wr1_valid}), 0);
    chk("midrst_avail", int'(avail_count), 32);
    chk("midrst_ready", int'(rn_ready), 1);
    cyc();
    reset_n = 1'b1;

    // Free at full count: clamp, optional sticky error
    cyc();
    cm_valid = 2'b01; cm0_preg = 6'd33;
    push_free(1, 0, 33, 0);
    cyc();
    cm_valid = 2'b00;
    cyc();
    #1 chk("avail_clamp", int'(avail_count), 32);
    chk("err_overflow", int'(err), EXP_ERR);
    rn_valid = 2'b11; fl_req0_data = 6'd14; fl_req1_data = 6'd15;
    push_alloc(1, 1, 14, 15);
    #1 chk("ready_after_reset", int'(rn_ready), 1);
    cyc();
    rn_valid = 2'b00;
    #1 chk("avail_final", int'(avail_count), 30);
    chk("err_sticky", int'(err), EXP_ERR);

    repeat (3) cyc();
    chk("alloc_queue_drained", q_alloc.size(), 0);
    chk("free_queue_drained", q_free.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
